// File: rtl/led_pattern_gen.sv
// led_pattern_gen
//   Prescales the system clock to a step rate and drives an LED bank in one
//   of four modes: binary count, bouncing scan, PWM breathing, static hold.
//
// Ports
//   clock       system clock (sysclk)
//   resetn      synchronous reset, active-low
//   enable      1 = run; 0 = freeze prescaler/pattern/PWM and blank the LEDs
//   mode        requested mode: 0 BINARY, 1 SCAN, 2 BREATHE, 3 HOLD
//   pattern_in  static pattern shown in HOLD mode
//   leds        registered LED drive, bit i = LED i
//   step_tick   one-cycle pulse per pattern step
//   active_mode mode currently applied (changes only at step ticks)
module led_pattern_gen #(
  parameter int SYS_CLK_FREQ = 30_000_000,
  parameter int STEP_FREQ    = 8,
  parameter int NUM_LEDS     = 8,
  parameter int PWM_BITS     = 4
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic [NUM_LEDS-1:0] pattern_in,
  output logic [NUM_LEDS-1:0] leds,
  output logic                step_tick,
  output logic [1:0]          active_mode
);

  typedef enum logic [1:0] {
    MODE_BINARY  = 2'd0,
    MODE_SCAN    = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_HOLD    = 2'd3
  } mode_t;

  localparam int DIV     = SYS_CLK_FREQ / STEP_FREQ;
  localparam int PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int POS_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(DIV - 1);
  localparam logic [POS_W-1:0]    POS_LAST   = POS_W'(NUM_LEDS - 1);
  localparam logic [PWM_BITS-1:0] LEVEL_MAX  = '1;
  localparam logic [NUM_LEDS-1:0] LED_ONE    = NUM_LEDS'(1);

  logic [PRESC_W-1:0]  prescaler;
  mode_t               mode_q;
  logic [NUM_LEDS-1:0] count;
  logic [POS_W-1:0]    pos;
  logic                scan_down;
  logic [PWM_BITS-1:0] level;
  logic                level_down;
  logic [PWM_BITS-1:0] pwm_cnt;

  logic [POS_W-1:0]    pos_adv;
  logic                scan_down_adv;
  logic [PWM_BITS-1:0] level_adv;
  logic                level_down_adv;
  logic [NUM_LEDS-1:0] led_pattern;

  assign active_mode = mode_q;

  // Scan position bounces between the end LEDs without repeating an endpoint.
  always_comb begin
    pos_adv       = pos;
    scan_down_adv = scan_down;
    if (NUM_LEDS > 1) begin
      if (!scan_down) begin
        if (pos == POS_LAST) begin
          scan_down_adv = 1'b1;
          pos_adv       = pos - 1'b1;
        end else begin
          pos_adv = pos + 1'b1;
        end
      end else begin
        if (pos == '0) begin
          scan_down_adv = 1'b0;
          pos_adv       = pos + 1'b1;
        end else begin
          pos_adv = pos - 1'b1;
        end
      end
    end
  end

  // Breathing level triangles 0..MAXL..0, again without repeated endpoints.
  always_comb begin
    level_adv      = level;
    level_down_adv = level_down;
    if (!level_down) begin
      if (level == LEVEL_MAX) begin
        level_down_adv = 1'b1;
        level_adv      = level - 1'b1;
      end else begin
        level_adv = level + 1'b1;
      end
    end else begin
      if (level == '0) begin
        level_down_adv = 1'b0;
        level_adv      = level + 1'b1;
      end else begin
        level_adv = level - 1'b1;
      end
    end
  end

  // LED image from the registered pattern state; registering it below puts
  // a pattern change on the pins one cycle after its step_tick.
  always_comb begin
    led_pattern = '0;
    case (mode_q)
      MODE_BINARY:  led_pattern = count;
      MODE_SCAN:    led_pattern = LED_ONE << pos;
      MODE_BREATHE: led_pattern = {NUM_LEDS{pwm_cnt < level}};
      MODE_HOLD:    led_pattern = pattern_in;
      default:      led_pattern = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      prescaler  <= '0;
      step_tick  <= 1'b0;
      leds       <= '0;
      mode_q     <= MODE_BINARY;
      count      <= '0;
      pos        <= '0;
      scan_down  <= 1'b0;
      level      <= '0;
      level_down <= 1'b0;
      pwm_cnt    <= '0;
    end else if (!enable) begin
      step_tick <= 1'b0;
      leds      <= '0;
    end else begin
      leds    <= led_pattern;
      pwm_cnt <= pwm_cnt + 1'b1;
      if (prescaler == PRESC_LAST) begin
        prescaler <= '0;
        step_tick <= 1'b1;
        if (mode_t'(mode) != mode_q) begin
          // A mode switch restarts every pattern rather than advancing it.
          mode_q     <= mode_t'(mode);
          count      <= '0;
          pos        <= '0;
          scan_down  <= 1'b0;
          level      <= '0;
          level_down <= 1'b0;
        end else begin
          case (mode_q)
            MODE_BINARY: count <= count + 1'b1;
            MODE_SCAN: begin
              pos       <= pos_adv;
              scan_down <= scan_down_adv;
            end
            MODE_BREATHE: begin
              level      <= level_adv;
              level_down <= level_down_adv;
            end
            default: ;
          endcase
        end
      end else begin
        prescaler <= prescaler + 1'b1;
        step_tick <= 1'b0;
      end
    end
  end

endmodule
